// File: rtl/tick_gen_pkg.sv
// Shared types and constants for the multi-channel tick generator.
//   tick_state_e : per-channel run state (idle / running)
//   TICK_DEF_DIV : divisor loaded into every channel at reset
//   tick_ch_w()  : width of a channel index for a given channel count (at least 1)
package tick_gen_pkg;

    typedef enum logic [0:0] {
        StIdle,
        StRun
    } tick_state_e;

    localparam int unsigned TICK_DEF_DIV = 100_000_000;

    function automatic int unsigned tick_ch_w(input int unsigned nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

// File: rtl/tick_channel.sv
// One tick generator channel: idle/run FSM, period counter, active divisor and a
// one-deep pending divisor that is applied at the next period boundary.
// Optional macro TICKGEN_SYNC_EN adds the sync_i phase-align input.
//   clk, reset  : system clock, asynchronous active-high reset
//   en_i        : run enable
//   sync_i      : restart the period in RUN (TICKGEN_SYNC_EN only)
//   wr_i        : accepted divisor write addressed to this channel
//   wr_div_i    : divisor value for wr_i
//   pend_o      : a divisor write is waiting for the period boundary
//   tick_o      : registered one-cycle tick
module tick_channel
    import tick_gen_pkg::*;
#(
    parameter int unsigned WIDTH   = 27,
    parameter int unsigned DEF_DIV = TICK_DEF_DIV
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en_i,
`ifdef TICKGEN_SYNC_EN
    input  logic             sync_i,
`endif
    input  logic             wr_i,
    input  logic [WIDTH-1:0] wr_div_i,
    output logic             pend_o,
    output logic             tick_o
);

    localparam logic [WIDTH-1:0] DefDiv = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] One    = WIDTH'(1);

    tick_state_e      state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             tick_q, tick_d;
    logic [WIDTH-1:0] new_div;
    logic             term;

    // D of 0 or 1 means every cycle; the explicit test avoids the wrap of 0 - 1.
    assign term = (div_q <= One) || (cnt_q == div_q - One);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        tick_d     = 1'b0;
        // Divisor to adopt at a boundary: a write landing on this edge beats an older pending one
        // (ready is low while pending, so both cannot happen together).
        new_div    = wr_i ? wr_div_i : (pend_q ? pend_div_q : div_q);

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (wr_i) begin
                    div_d = wr_div_i;
                end
                if (en_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!en_i) begin
                    // Disable wins over a coincident terminal count.
                    state_d = StIdle;
                    cnt_d   = '0;
                    div_d   = new_div;
                    pend_d  = 1'b0;
                end
`ifdef TICKGEN_SYNC_EN
                else if (sync_i) begin
                    cnt_d  = '0;
                    div_d  = new_div;
                    pend_d = 1'b0;
                end
`endif
                else if (term) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                    div_d  = new_div;
                    pend_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + One;
                    if (wr_i) begin
                        pend_d     = 1'b1;
                        pend_div_d = wr_div_i;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= DefDiv;
            pend_q     <= 1'b0;
            pend_div_q <= '0;
            tick_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
            tick_q     <= tick_d;
        end
    end

    assign pend_o = pend_q;
    assign tick_o = tick_q;

endmodule

// File: rtl/tick_gen_multi.sv
// Multi-channel programmable tick generator. NCH independent channels each emit a
// registered one-cycle tick every D cycles while enabled; divisors are written through
// a valid/ready port and take effect at the channel's next period boundary.
// Optional macro TICKGEN_SYNC_EN adds the sync input that phase-aligns all running channels.
//   clk, reset : system clock, asynchronous active-high reset
//   en         : per-channel run enable
//   cfg_valid  : divisor write request
//   cfg_ready  : write can be accepted this cycle (combinational on cfg_ch)
//   cfg_ch     : target channel; indices >= NCH are accepted and discarded
//   cfg_div    : new divisor
//   sync       : phase-align pulse (TICKGEN_SYNC_EN only)
//   tick       : per-channel tick pulses
module tick_gen_multi
    import tick_gen_pkg::*;
#(
    parameter int unsigned NCH     = 4,
    parameter int unsigned WIDTH   = 27,
    parameter int unsigned DEF_DIV = TICK_DEF_DIV
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NCH-1:0]            en,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    input  logic [tick_ch_w(NCH)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]          cfg_div,
`ifdef TICKGEN_SYNC_EN
    input  logic                      sync,
`endif
    output logic [NCH-1:0]            tick
);

    localparam int unsigned ChW = tick_ch_w(NCH);

    logic [NCH-1:0] pend;
    logic [NCH-1:0] wr;

    // Out-of-range channel indices match no entry and leave ready high.
    always_comb begin
        cfg_ready = 1'b1;
        for (int unsigned i = 0; i < NCH; i++) begin
            if (cfg_ch == ChW'(i)) begin
                cfg_ready = ~pend[i];
            end
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : gen_ch
        assign wr[g] = cfg_valid && cfg_ready && (cfg_ch == ChW'(g));

        tick_channel #(
            .WIDTH   (WIDTH),
            .DEF_DIV (DEF_DIV)
        ) u_ch (
            .clk      (clk),
            .reset    (reset),
            .en_i     (en[g]),
`ifdef TICKGEN_SYNC_EN
            .sync_i   (sync),
`endif
            .wr_i     (wr[g]),
            .wr_div_i (cfg_div),
            .pend_o   (pend[g]),
            .tick_o   (tick[g])
        );
    end

endmodule
